// File: rtl/abro_input_conditioner.sv
// Synchronizes and debounces the raw A, B and R inputs of the ABRO sequencer.
// Each channel has a registered level, one-cycle rise/fall pulses and a shared saturating glitch counter.
module abro_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_a,
   input  logic       raw_b,
   input  logic       raw_r,
   output logic       a_level,
   output logic       b_level,
   output logic       r_level,
   output logic       a_rise,
   output logic       b_rise,
   output logic       r_rise,
   output logic       a_fall,
   output logic       b_fall,
   output logic       r_fall,
   output logic [7:0] glitch_cnt
);

   // state  | meaning
   // LOW    | debounced level 0, waiting for s=1
   // CHK_HI | s went high, counting stable samples before accepting
   // HIGH   | debounced level 1, waiting for s=0
   // CHK_LO | s went low, counting stable samples before accepting
   typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

   localparam logic [7:0] TERM = 8'(DEBOUNCE_CYCLES - 1);

   logic [2:0] raw;
   logic [2:0] s1;
   logic [2:0] s;
   state_t     state_q [3];
   state_t     state_d [3];
   logic [7:0] cnt_q [3];
   logic [7:0] cnt_d [3];
   logic [2:0] level_q, level_d;
   logic [2:0] rise_q, rise_d;
   logic [2:0] fall_q, fall_d;
   logic [2:0] abort;
   logic [1:0] n_abort;
   logic [8:0] glitch_sum;
   logic [7:0] glitch_q;

   assign raw = {raw_r, raw_b, raw_a};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s  <= '0;
      end else begin
         s1 <= raw;
         s  <= s1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= LOW;
            cnt_q[i]   <= '0;
         end
         level_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         glitch_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
      end
   end

   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      abort   = '0;
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            LOW: begin
               if (s[i]) begin
                  state_d[i] = CHK_HI;
                  cnt_d[i]   = 8'd1;
               end
            end
            CHK_HI: begin
               if (!s[i]) begin
                  state_d[i] = LOW;
                  cnt_d[i]   = '0;
                  abort[i]   = 1'b1;
               end else if (cnt_q[i] == TERM) begin
                  state_d[i] = HIGH;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  rise_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            HIGH: begin
               if (!s[i]) begin
                  state_d[i] = CHK_LO;
                  cnt_d[i]   = 8'd1;
               end
            end
            CHK_LO: begin
               if (s[i]) begin
                  state_d[i] = HIGH;
                  cnt_d[i]   = '0;
                  abort[i]   = 1'b1;
               end else if (cnt_q[i] == TERM) begin
                  state_d[i] = LOW;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b0;
                  fall_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            default: begin
               state_d[i] = LOW;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Up to three channels may abort on the same edge; clamp instead of wrapping.
   always_comb begin
      n_abort    = 2'(abort[0]) + 2'(abort[1]) + 2'(abort[2]);
      glitch_sum = {1'b0, glitch_q} + {7'd0, n_abort};
   end

   assign {r_level, b_level, a_level} = level_q;
   assign {r_rise, b_rise, a_rise}    = rise_q;
   assign {r_fall, b_fall, a_fall}    = fall_q;
   assign glitch_cnt                  = glitch_q;

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Scoreboarded bench for abro_input_conditioner: a run-length reference model predicts every
// post-edge output vector, and a monitor compares the DUT against it each cycle.
module tb_abro_input_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       raw_a = 1'b0, raw_b = 1'b0, raw_r = 1'b0;
   logic       a_level, b_level, r_level;
   logic       a_rise, b_rise, r_rise;
   logic       a_fall, b_fall, r_fall;
   logic [7:0] glitch_cnt;

   abro_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset),
      .raw_a(raw_a), .raw_b(raw_b), .raw_r(raw_r),
      .a_level(a_level), .b_level(b_level), .r_level(r_level),
      .a_rise(a_rise), .b_rise(b_rise), .r_rise(r_rise),
      .a_fall(a_fall), .b_fall(b_fall), .r_fall(r_fall),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // Reference model: synchronizer pipeline plus a run length of samples disagreeing with the level.
   logic [2:0] m_s1 = '0, m_s = '0, m_lvl = '0;
   int         m_run [3] = '{0, 0, 0};
   int         m_glitch = 0;

   logic [16:0] sb_q [$];

   int a_rise_cyc = -1, a_fall_cyc = -1, b_rise_cyc = -1, r_rise_cyc = -1;
   int a_rise_n = 0, b_rise_n = 0;

   function automatic logic [16:0] dut_vec();
      return {r_level, b_level, a_level, r_rise, b_rise, a_rise,
              r_fall, b_fall, a_fall, glitch_cnt};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic ra, input logic rb, input logic rr, input logic rst);
      logic [2:0] e_rise, e_fall;
      int         g;
      @(negedge clk);
      cyc++;
      raw_a = ra; raw_b = rb; raw_r = rr; reset = rst;
      e_rise = '0; e_fall = '0; g = 0;
      if (!rst) begin
         m_s1 = '0; m_s = '0; m_lvl = '0; m_glitch = 0;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_s[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_lvl[i] = ~m_lvl[i];
                  if (m_lvl[i]) e_rise[i] = 1'b1; else e_fall[i] = 1'b1;
                  m_run[i] = 0;
               end
            end else if (m_run[i] != 0) begin
               m_run[i] = 0;
               g++;
            end
         end
         m_glitch = (m_glitch + g > 255) ? 255 : m_glitch + g;
         m_s  = m_s1;
         m_s1 = {rr, rb, ra};
      end
      sb_q.push_back({m_lvl, e_rise, e_fall, 8'(m_glitch)});
   endtask

   initial begin : monitor
      logic [16:0] exp_v, act_v;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            act_v = dut_vec();
            checks++;
            if (act_v !== exp_v) begin
               fails++;
               $display("FAIL cycle %0d outputs: got %05h expected %05h", cyc, act_v, exp_v);
            end
            if (a_rise) begin a_rise_cyc = cyc; a_rise_n++; end
            if (b_rise) begin b_rise_cyc = cyc; b_rise_n++; end
            if (a_fall) a_fall_cyc = cyc;
            if (r_rise) r_rise_cyc = cyc;
         end
      end
   end

   initial begin : stim
      int start;
      logic ra, rb, rr, rst;

      // 1: reset held with toggling raws, then 20 quiet cycles
      #2;
      chk("reset_vec_async", 32'(dut_vec()), 32'd0);
      for (int i = 0; i < 8; i++) cycle($urandom_range(1), $urandom_range(1), $urandom_range(1), 1'b0);
      chk("reset_vec_held", 32'(dut_vec()), 32'd0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("quiet_after_reset", 32'(dut_vec()), 32'd0);

      // 2: clean press and release on A
      a_rise_n = 0;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      start = cyc;
      for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("a_rise_latency", 32'(a_rise_cyc), 32'(start + D + 1));
      chk("a_rise_once", 32'(a_rise_n), 32'd1);
      chk("a_level_held", 32'(a_level), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      start = cyc;
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("a_fall_latency", 32'(a_fall_cyc), 32'(start + D + 1));

      // 3: glitch rejection on B
      b_rise_n = 0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("glitch_after_short", 32'(glitch_cnt), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("glitch_after_bounce", 32'(glitch_cnt), 32'd3);
      chk("b_level_stays_low", 32'(b_level), 32'd0);
      chk("b_no_rise", 32'(b_rise_n), 32'd0);

      // 4: simultaneous A/B
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      start = cyc;
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
      chk("ab_rise_a", 32'(a_rise_cyc), 32'(start + D + 1));
      chk("ab_rise_b", 32'(b_rise_cyc), 32'(start + D + 1));

      // 5: reset mid CHK_HI (cnt=2) on R, A/B high
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 chk("mid_reset_clears", 32'(dut_vec()), 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      start = cyc;
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("r_rise_after_reset", 32'(r_rise_cyc), 32'(start + D + 1));

      // Randomized mixed stimulus with occasional resets
      ra = 1'b0; rb = 1'b0; rr = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) ra = ~ra;
         if ($urandom_range(4) == 0) rb = ~rb;
         if ($urandom_range(5) == 0) rr = ~rr;
         rst = ($urandom_range(150) != 0);
         cycle(ra, rb, rr, rst);
      end

      // 6: saturation
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("glitch_saturated", 32'(glitch_cnt), 32'd255);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("glitch_stays_255", 32'(glitch_cnt), 32'd255);

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/abro_input_conditioner.md
# abro_input_conditioner

Front-end conditioning stage that sits directly upstream of the ABRO state machine. It synchronizes three asynchronous raw inputs (A, B and restart R) into the `clk` domain and debounces each one with a per-channel state machine. It presents clean debounced levels plus single-cycle rise and fall pulses. The sequence FSM consumes `a_level`/`b_level` (or the rise pulses) as its A/B inputs and `r_rise` as its sequence restart.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples of the new level required before the debounced level changes. Legal range is 2..255.
- `clk`  input  1  — single system clock; all logic is on the rising edge.
- `reset`  input  1  — asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `raw_a`, `raw_b`, `raw_r`  input  1 each  — asynchronous raw inputs (buttons/pins).
- `a_level`, `b_level`, `r_level`  output  1 each  — debounced levels.
- `a_rise`, `b_rise`, `r_rise`  output  1 each  — one-cycle pulse on a debounced 0→1 change.
- `a_fall`, `b_fall`, `r_fall`  output  1 each  — one-cycle pulse on a debounced 1→0 change.
- `glitch_cnt`  output  8  — saturating count of rejected transitions, summed over all channels.

## Operation

- **Per channel, synchronizer:** two flops, `s1 <= raw` then `s = s1`. Both flops reset to 0.
- **Per channel, debounce FSM:** states LOW, CHK_HI, HIGH, CHK_LO, with an 8-bit counter `cnt`.
  - **LOW** (`level=0`): if `s=1`, go to CHK_HI with `cnt<=1`; otherwise stay.
  - **CHK_HI:**
    - If `s=0`: go to LOW, `cnt<=0`, and count a glitch.
    - Else if `cnt==DEBOUNCE_CYCLES-1`: go to HIGH, `level<=1`, `rise<=1`.
    - Otherwise: `cnt<=cnt+1`.
  - **HIGH** (`level=1`): if `s=0`, go to CHK_LO with `cnt<=1`; otherwise stay.
  - **CHK_LO:** mirror of CHK_HI.
    - If `s=1`: go to HIGH and count a glitch.
    - Else if `cnt==DEBOUNCE_CYCLES-1`: go to LOW, `level<=0`, `fall<=1`.
- **Pulses:** `rise`/`fall` are registered and high for exactly one cycle. Each clears on the next edge unless the FSM re-fires, which cannot happen back-to-back.
- **Level during checks:** `level` holds its old value throughout CHK_HI/CHK_LO.
- **glitch_cnt:**
  - Increments by the number of channels that abort a CHK state on the same edge (0..3).
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- **Independence:** channels are fully independent. Simultaneous events on A and B produce `a_rise` and `b_rise` in the same cycle, which is required so the downstream A&&B path is reachable.
- **Reset:**
  - Asserting reset at any time, including mid-CHK, immediately forces all FSMs to LOW, clears `cnt`, synchronizers and `glitch_cnt`, and drives every output to 0.
  - If a raw input is held high through reset release, it debounces normally afterwards and produces a rise pulse.

## Timing

- **Rise latency** (D = DEBOUNCE_CYCLES): for raw going high and staying high, first captured by `s1` at edge 0:
  - `s=1` after edge 1.
  - FSM enters CHK_HI at edge 2.
  - `level` and `rise` are asserted after edge D+1.
  - `rise` deasserts after edge D+2.
- **Fall latency:** symmetric to rise.
- **Filtering:** any synchronized pulse shorter than D cycles never changes `level`. A synchronized pulse of exactly D cycles is accepted.
- **No combinational paths:** every output is a flop, with no path from input to output.
- **Reset timing:** deassertion is asynchronous to `clk`. The first FSM evaluation occurs on the first edge after release.

## Test plan

1. **Reset values.** Hold reset low with all raw inputs toggling. Required: all levels, rises, falls and `glitch_cnt` read 0. Release reset with raw inputs low: outputs stay 0 for 20 cycles.
2. **Clean press, D=4.** `raw_a`=1 sampled at edge 0 and held for 12 cycles. Required: `a_level`=1 after edge 5, `a_rise`=1 only in the cycle following edge 5. Release `raw_a`: `a_fall` pulses once, 5 edges after the sampled release.
3. **Glitch rejection.** `raw_b` high for 3 cycles, then low. Required: `b_level` stays 0, no `b_rise`, `glitch_cnt`=1. Bounce `raw_b` 1-0-1-0 with 1-cycle widths: `glitch_cnt` increments on each CHK abort and `b_level` stays 0.
4. **Simultaneous A/B.** `raw_a` and `raw_b` rise on the same edge and are held. Required: `a_rise` and `b_rise` are asserted in the same cycle, 5 edges later.
5. **Reset mid-operation.** `raw_r` high, then reset asserted while in CHK_HI with `cnt`=2. Required: all outputs 0 immediately. After release with `raw_r` still high: `r_rise` occurs after the full D+1 edge latency, measured from the first post-reset capture.
6. **Saturation.** Drive 300 aborted checks on `raw_a`. Required: `glitch_cnt` reads 255 and remains 255.
